// File: rtl/apb_slave_regfile_if.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile_if
// APB3 bus bundle between the requester and the apb_slave_regfile completer.
//
// Signals:
//   psel_i     requester -> completer  select
//   penable_i  requester -> completer  access phase
//   paddr_i    requester -> completer  byte address (32)
//   pwrite_i   requester -> completer  1 = write, 0 = read
//   pwdata_i   requester -> completer  write data (32)
//   pready_o   completer -> requester  transfer complete
//   prdata_o   completer -> requester  read data (32), valid with pready_o
//   pslverr_o  completer -> requester  error response, valid with pready_o
//
// Modports: master (requester side), slave (completer side).
// -----------------------------------------------------------------------------
interface apb_slave_regfile_if;
    logic        psel_i;
    logic        penable_i;
    logic [31:0] paddr_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic        pready_o;
    logic [31:0] prdata_o;
    logic        pslverr_o;

    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        input  pready_o, prdata_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        output pready_o, prdata_o, pslverr_o
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
// APB3 completer holding NUM_REGS 32-bit registers aliased across a 4 KB
// window at BASE_ADDR. Register 0 is a read-only ID; writing it, or touching
// any address outside the window, returns pslverr with no side effect.
// Every transfer inserts a fixed number of wait states.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   apb      slave modport of apb_slave_regfile_if (APB3 bus)
//
// Optional build macro:
//   APB_SLV_RAND_WAIT_EN  replaces WAIT_CYCLES with 0..3 pseudo-random wait
//                         states drawn from a free-running 4-bit LFSR.
//
// State table:
//   state  | meaning
//   S_IDLE | no transfer; a setup cycle latches the request
//   S_WAIT | inserting wait states, counter running down to 1
//   S_DONE | pready_o high for one cycle; write commits at end of cycle
// -----------------------------------------------------------------------------
module apb_slave_regfile #(
    parameter logic [31:0] BASE_ADDR   = 32'hDEAD_C000,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001,
    parameter logic [31:0] RST_VALUE   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    apb_slave_regfile_if.slave   apb
);

    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_q, wr_d;
    logic               err_q, err_d;
    logic [31:0]        wdata_q, wdata_d;

    logic               pready_q, pready_d;
    logic               pslverr_q, pslverr_d;
    logic [31:0]        prdata_q, prdata_d;

    logic [31:0]        regs [1:NUM_REGS-1];
    logic [31:0]        rd_view [0:NUM_REGS-1];

    logic               setup;
    logic               hit;
    logic [IDX_W-1:0]   live_idx;
    logic               live_err;
    logic [3:0]         load_cnt;
    logic [IDX_W-1:0]   cur_idx;
    logic               cur_wr;
    logic               cur_err;
    logic               go_done;
    logic               commit;

    // Only paddr[31:12] and the index bits matter; the rest is don't-care.
    logic               unused_paddr;
    assign unused_paddr = &{1'b0, apb.paddr_i[11:0]};

    assign setup    = apb.psel_i & ~apb.penable_i;
    assign hit      = (apb.paddr_i[31:12] == BASE_ADDR[31:12]);
    assign live_idx = apb.paddr_i[IDX_W+1:2];
    assign live_err = ~hit | (apb.pwrite_i & (live_idx == '0));

`ifdef APB_SLV_RAND_WAIT_EN
    logic [3:0] lfsr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 4'h9;
        end else begin
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end

    assign load_cnt = {2'b00, lfsr_q[1:0]};
`else
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    assign load_cnt = WAIT_CNT;
`endif

    // Read view: index 0 is the constant ID, the rest are storage.
    always_comb begin
        rd_view[0] = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            rd_view[i] = regs[i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        // In S_IDLE a zero-wait transfer completes straight from the live
        // decode, so the output path must look at the bus, not the latches.
        cur_idx = idx_q;
        cur_wr  = wr_q;
        cur_err = err_q;

        case (state_q)
            S_IDLE: begin
                cur_idx = live_idx;
                cur_wr  = apb.pwrite_i;
                cur_err = live_err;
                if (setup) begin
                    idx_d   = live_idx;
                    wr_d    = apb.pwrite_i;
                    err_d   = live_err;
                    wdata_d = apb.pwdata_i;
                    cnt_d   = load_cnt;
                    state_d = (load_cnt == 4'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!apb.psel_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        go_done   = (state_d == S_DONE);
        pready_d  = go_done;
        pslverr_d = go_done & cur_err;
        prdata_d  = (go_done & ~cur_err & ~cur_wr) ? rd_view[cur_idx] : 32'h0;
    end

    // A requester that drops psel in S_DONE has abandoned the transfer.
    assign commit = (state_q == S_DONE) & apb.psel_i & wr_q & ~err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= 32'h0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= RST_VALUE;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (commit && (idx_q == i[IDX_W-1:0])) begin
                    regs[i] <= wdata_q;
                end
            end
        end
    end

    assign apb.pready_o  = pready_q;
    assign apb.pslverr_o = pslverr_q;
    assign apb.prdata_o  = prdata_q;

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB3 completer that sits directly downstream of the team's APB requester and answers its transactions.
- Holds a small bank of 32-bit registers in a 4 KB address window.
- Inserts programmable wait states, and flags out-of-window accesses and writes to the read-only ID register with pslverr.
- Gives the requester a real read/modify/write target, e.g. its fixed address 32'hDEAD_CAFE.

Parameters:
- BASE_ADDR, 32'hDEAD_C000: window base; only paddr[31:12] are compared.
- NUM_REGS, 16: register count; power of 2, range 2..256; IDX_W = log2(NUM_REGS).
- WAIT_CYCLES, 0: fixed wait states per transfer, range 0..15.
- ID_VALUE, 32'hA9B0_0001: constant returned by register 0.
- RST_VALUE, 32'h0000_0000: reset value of registers 1..NUM_REGS-1.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset. One clock; reset is asynchronous and active-low.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (access phase).
- paddr_i  in  32  APB address.
- pwrite_i  in  1  1 = write, 0 = read.
- pwdata_i  in  32  write data.
- pready_o  out  1  transfer complete.
- prdata_o  out  32  read data, valid while pready_o=1.
- pslverr_o  out  1  error response, valid while pready_o=1.

Behaviour:
- Reset (async assert, sync release):
  - pready_o=0, pslverr_o=0, prdata_o=0.
  - FSM=S_IDLE, wait counter=0.
  - reg0 reads ID_VALUE; regs 1..N-1 = RST_VALUE.
- Decode, captured in the setup cycle:
  - hit = (paddr_i[31:12]==BASE_ADDR[31:12]).
  - idx = paddr_i[IDX_W+1:2]; paddr_i[1:0] ignored (no alignment error).
  - Registers alias throughout the window, so 32'hDEAD_CAFE maps to idx 15 with NUM_REGS=16.
  - err = !hit | (pwrite_i & idx==0).
- FSM states: S_IDLE, S_WAIT, S_DONE. All outputs registered.
  - S_IDLE, on psel_i & !penable_i (setup): latch idx, pwrite_i, pwdata_i, err; cnt<=WAIT_CYCLES.
    - If WAIT_CYCLES==0, go S_DONE.
    - Otherwise go S_WAIT.
    - psel_i with penable_i in S_IDLE (missing setup) is ignored; stay S_IDLE.
  - S_WAIT: pready_o=0; cnt decrements each cycle; at cnt==1 go S_DONE.
  - S_DONE: pready_o=1 for exactly one cycle; always return to S_IDLE.
    - pslverr_o = latched err.
    - prdata_o = register[idx] for an error-free read, else 0.
    - Write commits at the end of this cycle if !err.
- Latency:
  - pready_o is high in access cycle WAIT_CYCLES+1, counted from the first penable_i=1 cycle.
  - Zero-wait transfers complete in the first access cycle.
- prdata_o, pslverr_o, pready_o return to 0 on the cycle after S_DONE.
- Back-to-back: a setup presented in the cycle after S_DONE is accepted; no mandatory idle cycle.
- Errored writes leave every register unchanged; errored reads return 0.
- psel_i dropping while in S_WAIT or S_DONE (protocol violation): abort to S_IDLE, no write commit, outputs 0 next cycle.
- Reset asserted mid-transfer: immediate return to reset state; an uncommitted write is lost.

Optional Feature:
- Macro: APB_SLV_RAND_WAIT_EN.
- Defined:
  - Internal 4-bit LFSR, seed 4'h9 at reset, next = {lfsr[2:0], lfsr[3]^lfsr[2]}, advances every clock.
  - The setup cycle loads cnt = {2'b00, lfsr[1:0]}, giving 0..3 waits; WAIT_CYCLES is ignored.
- Not defined: cnt = WAIT_CYCLES; no LFSR logic present.

Test Plan:
- Reset → pready_o=0, pslverr_o=0, prdata_o=0; read 32'hDEAD_C004 returns 32'h0, pslverr_o=0.
- WAIT_CYCLES=0: write 32'h1234_5678 to 32'hDEAD_C008 → pready_o in first access cycle; read back 32'h1234_5678.
- WAIT_CYCLES=3: read 32'hDEAD_C008 → pready_o low for 3 access cycles, high on the 4th with prdata_o=32'h1234_5678.
- Write 32'hFFFF_FFFF to 32'hDEAD_C000 → pslverr_o=1; read 32'hDEAD_C000 returns 32'hA9B0_0001.
- Read 32'h1000_0000 → pslverr_o=1, prdata_o=0; same-cycle write there changes no register.
- Connected to the APB requester:
  - Each read of 32'hDEAD_CAFE returns the value of the preceding write; each write equals the preceding read + 1.
  - Assert reset_n=0 during S_WAIT → pready_o=0 immediately, reg15 unchanged.
